// File: rtl/alu_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_driver_if
//  Description : Request/response bundle between the CPU issue logic and
//                the ALU driver. master = issue side, slave = alu_driver.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_driver_if;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_op;
   logic        req_wide;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_z;
   logic [7:0]  rsp_flags;

   modport master (
      output req_valid, req_op, req_wide, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_z, rsp_flags
   );

   modport slave (
      input  req_valid, req_op, req_wide, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_z, rsp_flags
   );
endinterface
`default_nettype wire

// File: rtl/alu_driver.sv
`default_nettype none
// ============================================================================
//  Module      : alu_driver
//  Description : Sequential initiator for a combinational 8-bit ALU. Runs
//                narrow ops in one pass and builds 16-bit ops from two or
//                three passes; returns a registered response and keeps
//                sticky error flags.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_driver #(
   parameter logic [7:0] FLAG_MASK = 8'b00110011
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   alu_driver_if.slave     bus,
   output logic [7:0]      alu_a,
   output logic [7:0]      alu_b,
   output logic [7:0]      alu_op,
   input  wire logic [7:0] alu_z,
   input  wire logic [7:0] alu_flags,
   output logic [7:0]      sticky_flags,
   input  wire logic       sticky_clr
);

   // FSM states
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_P_LO  = 3'd1;
   localparam logic [2:0] S_P_HI  = 3'd2;
   localparam logic [2:0] S_P_FIX = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   // Operation classes, decided once at accept time
   localparam logic [2:0] K_NARROW = 3'd0;
   localparam logic [2:0] K_ADD    = 3'd1;
   localparam logic [2:0] K_SUB    = 3'd2;
   localparam logic [2:0] K_CMP    = 3'd3;
   localparam logic [2:0] K_BIT    = 3'd4;
   localparam logic [2:0] K_UNS    = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [2:0]  kind_q, kind_d;
   logic [7:0]  op_q, op_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [7:0]  alu_a_q, alu_a_d;
   logic [7:0]  alu_b_q, alu_b_d;
   logic [7:0]  alu_op_q, alu_op_d;
   logic [7:0]  z_lo_q, z_lo_d;
   logic [7:0]  z_hi_q, z_hi_d;
   logic [7:0]  flg_lo_q, flg_lo_d;
   logic [7:0]  flg_hi_q, flg_hi_d;
   logic [15:0] rsp_z_q, rsp_z_d;
   logic [7:0]  rsp_flags_q, rsp_flags_d;
   logic [7:0]  sticky_q, sticky_d;

   logic        accept;
   logic        rsp_hs;
   logic [2:0]  req_kind;

   assign accept = bus.req_valid && (state_q == S_IDLE);
   assign rsp_hs = bus.rsp_ready && (state_q == S_RESP);

   // Classify the incoming request by width and opcode
   always_comb begin
      req_kind = K_UNS;
      if (!bus.req_wide) begin
         req_kind = K_NARROW;
      end else begin
         case (bus.req_op[4:0])
            5'd0:                                   req_kind = K_ADD;
            5'd1:                                   req_kind = K_SUB;
            5'd4:                                   req_kind = K_CMP;
            5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
            5'd10, 5'd11:                           req_kind = K_BIT;
            default:                                req_kind = K_UNS;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; CMP runs the high pass first, carries add a fix pass
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (req_kind)
                  K_CMP:   state_d = S_P_HI;
                  K_UNS:   state_d = S_RESP;
                  default: state_d = S_P_LO;
               endcase
            end
         end
         S_P_LO: begin
            if (kind_q == K_NARROW || kind_q == K_CMP) begin
               state_d = S_RESP;
            end else begin
               state_d = S_P_HI;
            end
         end
         S_P_HI: begin
            case (kind_q)
               K_CMP:   state_d = S_P_LO;
               K_ADD:   state_d = flg_lo_q[0] ? S_P_FIX : S_RESP;
               K_SUB:   state_d = flg_lo_q[1] ? S_P_FIX : S_RESP;
               default: state_d = S_RESP;
            endcase
         end
         S_P_FIX: state_d = S_RESP;
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs are pure functions of the registered state
   always_comb begin
      bus.req_ready = (state_q == S_IDLE);
      bus.rsp_valid = (state_q == S_RESP);
   end

   // Datapath: load ALU operands on pass entry, capture results on pass exit
   always_comb begin
      kind_d      = kind_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      z_lo_d      = z_lo_q;
      z_hi_d      = z_hi_q;
      flg_lo_d    = flg_lo_q;
      flg_hi_d    = flg_hi_q;
      rsp_z_d     = rsp_z_q;
      rsp_flags_d = rsp_flags_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               kind_d = req_kind;
               op_d   = bus.req_op;
               a_d    = bus.req_a;
               b_d    = bus.req_b;
               case (req_kind)
                  K_UNS: begin
                     rsp_z_d     = 16'h0000;
                     rsp_flags_d = 8'h20;
                  end
                  K_CMP: begin
                     alu_a_d  = bus.req_a[15:8];
                     alu_b_d  = bus.req_b[15:8];
                     alu_op_d = bus.req_op;
                  end
                  default: begin
                     alu_a_d  = bus.req_a[7:0];
                     alu_b_d  = bus.req_b[7:0];
                     alu_op_d = bus.req_op;
                  end
               endcase
            end
         end
         S_P_LO: begin
            z_lo_d   = alu_z;
            flg_lo_d = alu_flags;
            case (kind_q)
               K_NARROW: begin
                  rsp_z_d     = {8'h00, alu_z};
                  rsp_flags_d = alu_flags;
               end
               K_CMP: begin
                  // Equal high bytes defer the decision to the low bytes
                  if (flg_hi_q[3]) begin
                     rsp_z_d     = {8'h00, alu_z};
                     rsp_flags_d = alu_flags;
                  end else begin
                     rsp_z_d     = {8'h00, z_hi_q};
                     rsp_flags_d = flg_hi_q;
                  end
               end
               default: begin
                  alu_a_d  = a_q[15:8];
                  alu_b_d  = b_q[15:8];
                  alu_op_d = op_q;
               end
            endcase
         end
         S_P_HI: begin
            z_hi_d   = alu_z;
            flg_hi_d = alu_flags;
            case (kind_q)
               K_CMP: begin
                  alu_a_d  = a_q[7:0];
                  alu_b_d  = b_q[7:0];
                  alu_op_d = op_q;
               end
               K_ADD: begin
                  if (flg_lo_q[0]) begin
                     alu_a_d  = alu_z;
                     alu_b_d  = 8'h01;
                     alu_op_d = 8'h00;
                  end else begin
                     rsp_z_d     = {alu_z, z_lo_q};
                     rsp_flags_d = {7'b0, alu_flags[0]};
                  end
               end
               K_SUB: begin
                  if (flg_lo_q[1]) begin
                     alu_a_d  = alu_z;
                     alu_b_d  = 8'h01;
                     alu_op_d = 8'h01;
                  end else begin
                     rsp_z_d     = {alu_z, z_lo_q};
                     rsp_flags_d = {6'b0, alu_flags[1], 1'b0};
                  end
               end
               default: begin
                  rsp_z_d     = {alu_z, z_lo_q};
                  rsp_flags_d = flg_lo_q | alu_flags;
               end
            endcase
         end
         S_P_FIX: begin
            z_hi_d  = alu_z;
            rsp_z_d = {alu_z, z_lo_q};
            if (kind_q == K_SUB) begin
               rsp_flags_d = {6'b0, flg_hi_q[1] | alu_flags[1], 1'b0};
            end else begin
               rsp_flags_d = {7'b0, flg_hi_q[0] | alu_flags[0]};
            end
         end
         default: begin
         end
      endcase
   end

   // Sticky flags: a handshake's contribution survives a same-cycle clear
   always_comb begin
      sticky_d = (sticky_clr ? 8'h00 : sticky_q) |
                 (rsp_hs ? (rsp_flags_q & FLAG_MASK) : 8'h00);
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kind_q      <= K_NARROW;
         op_q        <= 8'h00;
         a_q         <= 16'h0000;
         b_q         <= 16'h0000;
         alu_a_q     <= 8'h00;
         alu_b_q     <= 8'h00;
         alu_op_q    <= 8'h00;
         z_lo_q      <= 8'h00;
         z_hi_q      <= 8'h00;
         flg_lo_q    <= 8'h00;
         flg_hi_q    <= 8'h00;
         rsp_z_q     <= 16'h0000;
         rsp_flags_q <= 8'h00;
         sticky_q    <= 8'h00;
      end else begin
         kind_q      <= kind_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         z_lo_q      <= z_lo_d;
         z_hi_q      <= z_hi_d;
         flg_lo_q    <= flg_lo_d;
         flg_hi_q    <= flg_hi_d;
         rsp_z_q     <= rsp_z_d;
         rsp_flags_q <= rsp_flags_d;
         sticky_q    <= sticky_d;
      end
   end

   assign alu_a         = alu_a_q;
   assign alu_b         = alu_b_q;
   assign alu_op        = alu_op_q;
   assign bus.rsp_z     = rsp_z_q;
   assign bus.rsp_flags = rsp_flags_q;
   assign sticky_flags  = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_driver
//  Description : Self-checking bench for alu_driver with a behavioural
//                8-bit ALU, directed vectors and a response scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_driver;

   logic       clk;
   logic       rst_n;
   logic [7:0] alu_a, alu_b, alu_op;
   logic [7:0] alu_z, alu_flags;
   logic [7:0] sticky_flags;
   logic       sticky_clr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] z;
      logic [7:0]  f;
   } exp_t;
   exp_t sb_q[$];

   logic [7:0] tr_a  [0:19];
   logic [7:0] tr_b  [0:19];
   logic [7:0] tr_op [0:19];

   alu_driver_if bus ();

   alu_driver dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_z        (alu_z),
      .alu_flags    (alu_flags),
      .sticky_flags (sticky_flags),
      .sticky_clr   (sticky_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural combinational ALU
   logic [8:0]  m_sum;
   logic [15:0] m_prod;
   logic        m_cmp;
   always_comb begin
      alu_z     = 8'h00;
      alu_flags = 8'h00;
      m_sum     = 9'h000;
      m_prod    = 16'h0000;
      m_cmp     = 1'b0;
      case (alu_op[4:0])
         5'd0: begin
            m_sum        = {1'b0, alu_a} + {1'b0, alu_b};
            alu_z        = m_sum[7:0];
            alu_flags[0] = m_sum[8];
         end
         5'd1: begin
            alu_z        = alu_a - alu_b;
            alu_flags[1] = (alu_a < alu_b);
         end
         5'd2: begin
            m_prod       = alu_a * alu_b;
            alu_z        = m_prod[7:0];
            alu_flags[0] = (m_prod[15:8] != 8'h00);
         end
         5'd3: begin
            if (alu_b == 8'h00) alu_flags[4] = 1'b1;
            else                alu_z = alu_a / alu_b;
         end
         5'd4: begin
            case (alu_op[7:5])
               3'd0: m_cmp = (alu_a == alu_b);
               3'd1: m_cmp = (alu_a != alu_b);
               3'd2: m_cmp = (alu_a <  alu_b);
               3'd3: m_cmp = (alu_a <= alu_b);
               3'd4: m_cmp = (alu_a >  alu_b);
               3'd5: m_cmp = (alu_a >= alu_b);
               default: m_cmp = 1'b0;
            endcase
            alu_z        = {7'b0, m_cmp};
            alu_flags[2] = (alu_a > alu_b);
            alu_flags[3] = (alu_a == alu_b);
         end
         5'd5:  alu_z = alu_a & alu_b;
         5'd6:  alu_z = alu_a | alu_b;
         5'd7:  alu_z = alu_a ^ alu_b;
         5'd8:  alu_z = ~alu_a;
         5'd9:  alu_z = ~(alu_a & alu_b);
         5'd10: alu_z = ~(alu_a | alu_b);
         5'd11: alu_z = ~(alu_a ^ alu_b);
         default: alu_flags[5] = 1'b1;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: pops on every response handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("rsp_z", {16'h0, bus.rsp_z}, {16'h0, e.z});
               check("rsp_flags", {24'h0, bus.rsp_flags}, {24'h0, e.f});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Issue one request; measure latency, optionally back-pressure or clear
   task automatic do_req(input logic [7:0] op, input logic wide,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ez, input logic [7:0] ef,
                         input int elat, input int hold, input bit clr_hs);
      int lat;
      logic [15:0] z0;
      logic [7:0]  f0;
      @(posedge clk); #1;
      check("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_wide  = wide;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.rsp_ready = (hold == 0);
      sb_q.push_back('{ez, ef});
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("req_ready_busy", {31'b0, bus.req_ready}, 32'd0);
      lat = 1;
      while (!bus.rsp_valid && lat < 19) begin
         tr_a[lat]  = alu_a;
         tr_b[lat]  = alu_b;
         tr_op[lat] = alu_op;
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, elat);
      if (!bus.rsp_valid) begin
         bus.rsp_ready = 1'b1;
         return;
      end
      z0 = bus.rsp_z;
      f0 = bus.rsp_flags;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
         check("hold_rsp_stable", {8'h0, bus.rsp_z, bus.rsp_flags}, {8'h0, z0, f0});
         check("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      if (clr_hs) sticky_clr = 1'b1;
      @(posedge clk); #1;
      sticky_clr = 1'b0;
      check("post_hs_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("post_hs_ready", {31'b0, bus.req_ready}, 32'd1);
   endtask

   initial begin
      rst_n         = 1'b0;
      sticky_clr    = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 8'h00;
      bus.req_wide  = 1'b0;
      bus.req_a     = 16'h0000;
      bus.req_b     = 16'h0000;
      bus.rsp_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_outputs", {alu_a, alu_b, alu_op, sticky_flags}, 32'h0);
      check("rst_rsp", {7'b0, bus.rsp_valid, bus.rsp_z, bus.rsp_flags}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);

      // Narrow ADD with carry out
      do_req(8'h00, 1'b0, 16'h00F0, 16'h0020, 16'h0010, 8'h01, 2, 0, 1'b0);
      check("sticky_narrow_add", {24'h0, sticky_flags}, 32'h01);

      // Wide MUL: no pass, clear on handshake keeps new flags
      do_req(8'h02, 1'b1, 16'h0003, 16'h0004, 16'h0000, 8'h20, 1, 0, 1'b1);
      check("mul_alu_unchanged", {16'h0, alu_op, alu_a}, {16'h0, 8'h00, 8'hF0});
      check("sticky_clr_hs", {24'h0, sticky_flags}, 32'h20);

      // Wide ADD with fix pass
      do_req(8'h00, 1'b1, 16'h12FF, 16'h0001, 16'h1300, 8'h00, 4, 0, 1'b0);
      check("add_fix_ops", {8'h0, tr_op[1], tr_op[2], tr_op[3]}, 32'h0);
      check("add_fix_operands", {16'h0, tr_a[3], tr_b[3]}, 32'h1201);
      do_req(8'h00, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 8'h01, 4, 0, 1'b0);
      check("sticky_after_add", {24'h0, sticky_flags}, 32'h21);

      // Wide SUB with borrow fix
      do_req(8'h01, 1'b1, 16'h1000, 16'h0001, 16'h0FFF, 8'h00, 4, 0, 1'b0);
      do_req(8'h01, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 8'h02, 4, 0, 1'b0);
      check("sticky_after_sub", {24'h0, sticky_flags}, 32'h23);

      // Wide ADD without carry, wide bitwise OR
      do_req(8'h00, 1'b1, 16'h1122, 16'h0101, 16'h1223, 8'h00, 3, 0, 1'b0);
      do_req(8'h06, 1'b1, 16'h1234, 16'h00F0, 16'h12F4, 8'h00, 3, 0, 1'b0);
      check("or_pass_order", {16'h0, tr_a[1], tr_a[2]}, 32'h3412);

      // Wide CMP (a >= b), high pass first
      do_req(8'hA4, 1'b1, 16'h1234, 16'h1233, 16'h0001, 8'h04, 3, 0, 1'b0);
      check("cmp_pass_order", {tr_op[1], tr_op[2], tr_a[1], tr_a[2]}, 32'hA4A41234);
      do_req(8'hA4, 1'b1, 16'h1134, 16'h1233, 16'h0000, 8'h00, 3, 0, 1'b0);

      // Wide unknown opcode
      do_req(8'h0D, 1'b1, 16'h5555, 16'hAAAA, 16'h0000, 8'h20, 1, 0, 1'b0);

      // Backpressure on a narrow XOR
      do_req(8'h07, 1'b0, 16'h005A, 16'h00FF, 16'h00A5, 8'h00, 2, 5, 1'b0);

      // Asynchronous reset in the middle of a wide XOR high pass
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_op    = 8'h07;
      bus.req_wide  = 1'b1;
      bus.req_a     = 16'hF0F0;
      bus.req_b     = 16'h0FF0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      check("xor_p_hi_alu", {16'h0, alu_a, alu_op}, {16'h0, 8'hF0, 8'h07});
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_alu", {8'h0, alu_a, alu_b, alu_op}, 32'h0);
      check("async_rst_rsp", {7'b0, bus.rsp_valid, bus.rsp_z, bus.rsp_flags}, 32'h0);
      check("async_rst_sticky", {24'h0, sticky_flags}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);

      // Narrow AND after reset
      do_req(8'h05, 1'b0, 16'h000F, 16'h003C, 16'h000C, 8'h00, 2, 0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
